// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit that owns the HI/LO registers.
// MULT/MULTU use shift-add on a 64-bit accumulator. DIV/DIVU use restoring
// shift-subtract division. Every operation takes a fixed 33 cycles after
// start: 32 iterations followed by one sign-fix/commit cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state;
    state_t state_next;

    // Operation context, captured when start is accepted in IDLE.
    logic             is_div_q;
    logic             neg_a;
    logic             neg_b;
    logic             div_zero;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt;

    // Working pair.
    // Multiply: {partial product, multiplier shifting out}.
    // Divide:   {partial remainder, dividend shifting into the quotient}.
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;

    // Start-time operand conditioning.
    logic             op_signed;
    logic [WIDTH-1:0] rs_abs;
    logic [WIDTH-1:0] rt_abs;

    // One-iteration results.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_sub;
    logic             div_ok;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;

    // Sign-corrected results written during FIX.
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   commit_hi;
    logic [WIDTH-1:0]   commit_lo;

    assign busy = (state != IDLE);

    // Signed ops iterate on magnitudes; the sign flags are re-applied in FIX.
    always_comb begin
        op_signed = ~op[0];
        rs_abs    = (op_signed && rs_data[WIDTH-1]) ? (~rs_data + 1'b1) : rs_data;
        rt_abs    = (op_signed && rt_data[WIDTH-1]) ? (~rt_data + 1'b1) : rt_data;
    end

    // One shift-add or restoring shift-subtract step on the working pair.
    always_comb begin
        mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, a_q} : '0);
        div_shift = {work_hi, work_lo[WIDTH-1]};
        div_ok    = (div_shift >= {1'b0, b_q});
        div_sub   = div_shift[WIDTH-1:0] - b_q;
        if (is_div_q) begin
            iter_hi = div_ok ? div_sub : div_shift[WIDTH-1:0];
            iter_lo = {work_lo[WIDTH-2:0], div_ok};
        end else begin
            iter_hi = mul_sum[WIDTH:1];
            iter_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
        end
    end

    // Sign correction and the divide-by-zero override for the commit values.
    always_comb begin
        prod_raw = {work_hi, work_lo};
        prod_fix = (neg_a ^ neg_b) ? (~prod_raw + 1'b1) : prod_raw;
        quot_fix = (neg_a ^ neg_b) ? (~work_lo + 1'b1) : work_lo;
        rem_fix  = neg_a ? (~work_hi + 1'b1) : work_hi;
        if (is_div_q) begin
            // With a zero divisor the remainder ends up as |rs|, so re-signing
            // it gives back the original rs value; the quotient is forced.
            commit_hi = rem_fix;
            commit_lo = div_zero ? '1 : quot_fix;
        end else begin
            commit_hi = prod_fix[2*WIDTH-1:WIDTH];
            commit_lo = prod_fix[WIDTH-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: launch on start, 32 iterations, then a single fix cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == LAST_ITER) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture at launch and the iteration datapath while calculating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_div_q <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div_zero <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            cnt      <= '0;
            work_hi  <= '0;
            work_lo  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div_q <= op[1];
                        neg_a    <= op_signed & rs_data[WIDTH-1];
                        neg_b    <= op_signed & rt_data[WIDTH-1];
                        div_zero <= (rt_data == '0);
                        a_q      <= rs_abs;
                        b_q      <= rt_abs;
                        cnt      <= '0;
                        work_hi  <= '0;
                        work_lo  <= op[1] ? rs_abs : rt_abs;
                    end
                end
                CALC: begin
                    work_hi <= iter_hi;
                    work_lo <= iter_lo;
                    cnt     <= cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // HI/LO: committed in FIX; mthi/mtlo writes are honoured only while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIX) begin
            hi <= commit_hi;
            lo <= commit_lo;
        end else if (state == IDLE) begin
            if (mthi) hi <= rs_data;
            if (mtlo) lo <= rs_data;
        end
    end

    // Done pulses for the single cycle that follows the commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done <= 1'b0;
        end else begin
            done <= (state == FIX);
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed checks of mult_div_unit with hand-computed
// HI/LO values, cycle-exact latency, done pulses, ignored inputs while busy,
// and asynchronous reset in the middle of an operation.
module tb_mult_div_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mthi;
    logic        mtlo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Count done pulses at rising edges so that reads at falling edges are race-free.
    always @(posedge clk) if (done) done_cnt++;

    // Watchdog so that the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after E0.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Full operation; returns at the falling edge after E33 (the done cycle).
    task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        applyStimulus(o, a, b);
        repeat (33) @(negedge clk);
        checkOutput({tag, "_done"}, 64'(done), 64'(1'b1));
        checkOutput({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        checkOutput({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        int busy_low;
        int early_done;
        int saved_cnt;

        reset   = 1'b0;
        start   = 1'b0;
        op      = OP_MULT;
        rs_data = '0;
        rt_data = '0;
        mthi    = 1'b0;
        mtlo    = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("rst_hi", 64'(hi), 64'h0);
        checkOutput("rst_lo", 64'(lo), 64'h0);
        checkOutput("rst_busy", 64'(busy), 64'h0);
        checkOutput("rst_done", 64'(done), 64'h0);
        reset = 1'b1;
        @(negedge clk);

        // MULTU max*max with cycle-exact busy/done.
        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkOutput("multu_busy_e0", 64'(busy), 64'h1);
        busy_low   = 0;
        early_done = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (!busy) busy_low++;
            if (done) early_done++;
        end
        checkOutput("multu_busy_held", 64'(busy_low), 64'h0);
        checkOutput("multu_no_early_done", 64'(early_done), 64'h0);
        @(negedge clk);
        checkOutput("multu_busy_e33", 64'(busy), 64'h0);
        checkOutput("multu_done_e33", 64'(done), 64'h1);
        checkOutput("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        checkOutput("multu_lo", 64'(lo), 64'h0000_0001);
        @(negedge clk);
        checkOutput("multu_done_e34", 64'(done), 64'h0);
        checkOutput("multu_done_count", 64'(done_cnt), 64'd1);

        // MULT -3*7, then DIV -7/2 launched in the done cycle.
        runOp("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        runOp("div_b2b", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // Unsigned divide and divide-by-zero cases.
        runOp("divu", OP_DIVU, 32'hDEAD_BEEF, 32'h10, 32'h0000_000F, 32'h0DEA_DBEE);
        runOp("divu_zero", OP_DIVU, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF);
        runOp("div_zero", OP_DIV, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

        // Most-negative operand boundaries.
        runOp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        runOp("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

        // start/op/operands/mthi while busy are all ignored.
        @(negedge clk);
        applyStimulus(OP_MULTU, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        start   = 1'b1;
        op      = OP_DIVU;
        rs_data = 32'h0000_AAAA;
        rt_data = 32'd3;
        mthi    = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        mthi    = 1'b0;
        checkOutput("busy_mthi_ignored", 64'(hi), 64'h4000_0000);
        checkOutput("busy_still", 64'(busy), 64'h1);
        saved_cnt = done_cnt;
        repeat (23) @(negedge clk);
        checkOutput("ign_done", 64'(done), 64'h1);
        checkOutput("ign_hi", 64'(hi), 64'h0);
        checkOutput("ign_lo", 64'(lo), 64'd30);
        repeat (5) @(negedge clk);
        checkOutput("ign_single_done", 64'(done_cnt), 64'(saved_cnt + 1));
        checkOutput("ign_idle", 64'(busy), 64'h0);

        // mthi+mtlo together with start: written at E0, then overwritten by commit.
        mthi = 1'b1;
        mtlo = 1'b1;
        applyStimulus(OP_MULTU, 32'h55, 32'd2);
        mthi = 1'b0;
        mtlo = 1'b0;
        checkOutput("mtx_start_hi", 64'(hi), 64'h55);
        checkOutput("mtx_start_lo", 64'(lo), 64'h55);
        checkOutput("mtx_start_busy", 64'(busy), 64'h1);
        repeat (33) @(negedge clk);
        checkOutput("mtx_commit_hi", 64'(hi), 64'h0);
        checkOutput("mtx_commit_lo", 64'(lo), 64'hAA);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        repeat (14) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_hi", 64'(hi), 64'h0);
        checkOutput("mid_rst_lo", 64'(lo), 64'h0);
        checkOutput("mid_rst_busy", 64'(busy), 64'h0);
        checkOutput("mid_rst_done", 64'(done), 64'h0);
        saved_cnt = done_cnt;
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("mid_rst_no_done", 64'(done_cnt), 64'(saved_cnt));
        checkOutput("mid_rst_idle", 64'(busy), 64'h0);
        mtlo    = 1'b1;
        rs_data = 32'hDEAD_BEEF;
        @(negedge clk);
        mtlo    = 1'b0;
        checkOutput("mtlo_lo", 64'(lo), 64'hDEAD_BEEF);
        checkOutput("mtlo_hi", 64'(hi), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
